pseudo_spi_rx_intf: RTL

- Receive-direction counterpart of the pseudo-SPI scan-load interface.
- Drives the two-phase scan clocks (SCLK1/SCLK2) and the scan-chain capture select (SEL) so the chain loads its parallel inputs (ADC results, status bits).
- Shifts the chain out serially, deserializes the bits LSB-first into bytes and writes each byte into the 512x8 SRAM through the single-port CEN/A/D_WE/D interface.
- Lets on-chip logic, or a scan host reading the SRAM, retrieve scan-chain contents without an external tester.

---
 rtl/pseudo_spi_rx_intf_pkg.sv | 30 +++
 rtl/pseudo_spi_rx_intf_scan_phase_gen.sv | 40 ++++
 rtl/pseudo_spi_rx_intf.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pseudo_spi_rx_intf_pkg.sv
// Purpose: shared constants, state encoding and helpers for the pseudo-SPI receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pseudo_spi_rx_intf_pkg;

    localparam int MEM_DATA_W  = 8;   // SRAM word width, also bits per deserialized byte
    localparam int MEM_ADDR_W  = 9;   // SRAM address width (512 words)
    localparam int DATA_LEN_W  = 8;   // width of the byte-count input
    localparam int SCLK_PHASES = 4;   // cycles per scan clock pair (S1, gap, S2, gap)
    localparam int CAPT_CYCLES = 4;   // cycles spent with SEL=1 loading the chain
    localparam int PHASE_W     = $clog2(SCLK_PHASES);

    // Gray-style walk so the common transitions flip a single bit, matching the transmitter.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_CAPT   = 3'b001,
        ST_BIT_S1 = 3'b011,
        ST_BIT_G1 = 3'b010,
        ST_BIT_S2 = 3'b110,
        ST_BIT_G2 = 3'b111,
        ST_WRITE  = 3'b101,
        ST_DONE   = 3'b100
    } rx_state_e;

    // States in which a low BGN aborts the transfer.
    function automatic logic is_active(input rx_state_e s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/pseudo_spi_rx_intf_scan_phase_gen.sv
// Purpose: 2-bit scan phase counter giving non-overlapping SCLK1/SCLK2 pulses and a phase-end strobe.
// Latency: pulse flags describe the next cycle's phase so the caller can register them directly.
// Backpressure: none; counter is held at phase 0 whenever run is low.
module pseudo_spi_rx_intf_scan_phase_gen
    import pseudo_spi_rx_intf_pkg::*;
(
    input  logic CLK,
    input  logic rst_n,
    input  logic run,
    output logic sclk1_nxt,
    output logic sclk2_nxt,
    output logic phase_end
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    // Advance while running; restart from phase 0 otherwise.
    always_comb begin
        phase_d = '0;
        if (run) begin
            phase_d = phase_q + PHASE_W'(1);
        end
    end

    // Phase register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase 1 carries SCLK1, phase 3 carries SCLK2; 0 and 2 are guard gaps.
    assign sclk1_nxt = (phase_d == PHASE_W'(1));
    assign sclk2_nxt = (phase_d == PHASE_W'(3));
    assign phase_end = run && (phase_q == PHASE_W'(SCLK_PHASES - 1));

endmodule

// File: rtl/pseudo_spi_rx_intf.sv
// Purpose: capture a scan chain, shift it out LSB-first and write the bytes to SRAM at descending addresses.
// Latency: first write 36 cycles after leaving IDLE, then one byte every 33 cycles; done the cycle after the last write.
// Backpressure: none; BGN low aborts any active transfer, and DONE holds until BGN drops.
module pseudo_spi_rx_intf #(
    parameter int MEMORY_DATA_WIDTH = pseudo_spi_rx_intf_pkg::MEM_DATA_W,
    parameter int MEMORY_ADDR_WIDTH = pseudo_spi_rx_intf_pkg::MEM_ADDR_W,
    parameter int RESERVED_DATA_LEN = pseudo_spi_rx_intf_pkg::DATA_LEN_W
) (
    input  logic                         CLK,
    input  logic                         rst_n,
    input  logic                         BGN,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
    input  logic                         SPI_SI,
    output logic                         SCLK1,
    output logic                         SCLK2,
    output logic                         SEL,
    output logic                         LAT,
    output logic                         CEN,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic                         D_WE,
    output logic [MEMORY_DATA_WIDTH-1:0] D,
    output logic                         spi_is_done
);
    import pseudo_spi_rx_intf_pkg::*;

    localparam int BIT_W = $clog2(MEMORY_DATA_WIDTH);

    rx_state_e                    state_q, state_d;
    logic [BIT_W-1:0]             bitcnt_q, bitcnt_d;
    logic [RESERVED_DATA_LEN-1:0] bytecnt_q, bytecnt_d;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEMORY_DATA_WIDTH-1:0] shift_q, shift_d;
    logic [MEMORY_ADDR_WIDTH-1:0] a_q, a_d;
    logic [MEMORY_DATA_WIDTH-1:0] dat_q, dat_d;
    logic                         sclk1_q, sclk1_d;
    logic                         sclk2_q, sclk2_d;
    logic                         sel_q, sel_d;
    logic                         cen_q, cen_d;
    logic                         we_q, we_d;
    logic                         done_q, done_d;
    logic                         abort;
    logic                         cap_sclk1, cap_sclk2, cap_end;

    // Capture pulse timing comes from the shared phase generator.
    pseudo_spi_rx_intf_scan_phase_gen u_capt_phase (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .run       (state_q == ST_CAPT),
        .sclk1_nxt (cap_sclk1),
        .sclk2_nxt (cap_sclk2),
        .phase_end (cap_end)
    );

    // Next state, counters, shift register and registered-output values.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        bytecnt_d = bytecnt_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        a_d       = a_q;
        dat_d     = dat_q;
        abort     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (BGN) begin
                    if (DATA_LEN != '0) begin
                        bytecnt_d = DATA_LEN;
                        addr_d    = ADDR_BGN - 1'b1;
                        bitcnt_d  = '0;
                        state_d   = ST_CAPT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CAPT:   if (cap_end) state_d = ST_BIT_S1;
            ST_BIT_S1: state_d = ST_BIT_G1;
            ST_BIT_G1: state_d = ST_BIT_S2;
            ST_BIT_S2: state_d = ST_BIT_G2;
            ST_BIT_G2: begin
                bitcnt_d = bitcnt_q + 1'b1;
                state_d  = (bitcnt_q == BIT_W'(MEMORY_DATA_WIDTH - 1)) ? ST_WRITE : ST_BIT_S1;
            end
            ST_WRITE: begin
                addr_d    = addr_q - 1'b1;
                bytecnt_d = bytecnt_q - 1'b1;
                state_d   = (bytecnt_q == RESERVED_DATA_LEN'(1)) ? ST_DONE : ST_BIT_S1;
            end
            ST_DONE:   if (!BGN) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // A dropped BGN wins over everything; the partial byte is simply forgotten.
        if (is_active(state_q) && !BGN) begin
            abort     = 1'b1;
            state_d   = ST_IDLE;
            bitcnt_d  = '0;
            bytecnt_d = '0;
            addr_d    = '0;
        end

        // Sample the chain tail on the edge that raises SCLK1, before it moves the chain.
        if (state_d == ST_BIT_S1) begin
            shift_d[bitcnt_d] = SPI_SI;
        end

        sclk1_d = (state_d == ST_BIT_S1) || ((state_d == ST_CAPT) && cap_sclk1);
        sclk2_d = (state_d == ST_BIT_S2) || ((state_d == ST_CAPT) && cap_sclk2);
        sel_d   = (state_d == ST_CAPT);
        cen_d   = (state_d != ST_WRITE);
        we_d    = (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);

        if (state_d == ST_WRITE) begin
            a_d   = addr_q;
            dat_d = shift_q;
        end
        if (abort) begin
            a_d   = '0;
            dat_d = '0;
        end
    end

    // State, counters and glitch-free registered outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            bytecnt_q <= '0;
            addr_q    <= '0;
            shift_q   <= '0;
            a_q       <= '0;
            dat_q     <= '0;
            sclk1_q   <= 1'b0;
            sclk2_q   <= 1'b0;
            sel_q     <= 1'b0;
            cen_q     <= 1'b1;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            bytecnt_q <= bytecnt_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            a_q       <= a_d;
            dat_q     <= dat_d;
            sclk1_q   <= sclk1_d;
            sclk2_q   <= sclk2_d;
            sel_q     <= sel_d;
            cen_q     <= cen_d;
            we_q      <= we_d;
            done_q    <= done_d;
        end
    end

    assign SCLK1       = sclk1_q;
    assign SCLK2       = sclk2_q;
    assign SEL         = sel_q;
    assign LAT         = 1'b0;
    assign CEN         = cen_q;
    assign D_WE        = we_q;
    assign A           = a_q;
    assign D           = dat_q;
    assign spi_is_done = done_q;

endmodule
